// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the RV32I data-memory responder.
// Holds load/store size encodings, FSM state and request-kind enums, and the func3 legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    typedef enum logic {
        REQ_LOAD,
        REQ_STORE
    } dmem_req_t;

    // Size encodings with no meaning for the given request kind; alignment is checked separately.
    function automatic logic f3_illegal(input dmem_req_t kind, input logic [2:0] f3);
        if (kind == REQ_STORE) begin
            return f3 > F3_W;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and the core's load/store data.
// Produces write byte-enables, the replicated write word, extended load data and the alignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [15:0]        w_shifted;
    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;
    logic signed [31:0] w_byte_sx;
    logic signed [31:0] w_half_sx;

    // The addressed byte/half lands in the low lanes; only 16 bits are ever needed from it.
    assign w_shifted = 16'(i_rword >> {i_addr_lo, 3'b000});
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted;
    assign w_byte_sx = w_byte;
    assign w_half_sx = w_half;

    always_comb begin
        o_byte_en    = 4'b0000;
        o_wword      = i_wdata;
        o_rdata      = 32'h0;
        o_misaligned = 1'b0;
        case (i_func3)
            F3_B: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wword   = {4{i_wdata[7:0]}};
                o_rdata   = w_byte_sx;
            end
            F3_BU: begin
                o_rdata = {24'h0, w_shifted[7:0]};
            end
            F3_H: begin
                o_byte_en    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wword      = {2{i_wdata[15:0]}};
                o_rdata      = w_half_sx;
                o_misaligned = i_addr_lo[0];
            end
            F3_HU: begin
                o_rdata      = {16'h0, w_shifted};
                o_misaligned = i_addr_lo[0];
            end
            F3_W: begin
                o_byte_en    = 4'b1111;
                o_rdata      = i_rword;
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised synchronous RAM serving RV32I loads/stores with
// configurable wait states, a ready/stall handshake and a fault pulse for bad accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_stall,
    output logic        o_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_fault;

    dmem_req_t        r_kind;
    logic [2:0]       r_func3;
    logic [AW+1:0]    r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rword;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req;
    dmem_req_t        w_kind;
    logic [1:0]       w_sel_addr;
    logic [2:0]       w_sel_f3;
    logic             w_misaligned;
    logic             w_invalid;
    logic             w_access;
    logic [AW-1:0]    w_widx;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_wword;
    logic [31:0]      w_ld_data;
    logic             w_unused_addr;

    assign w_req  = i_mem_read | i_mem_write;
    assign w_kind = i_mem_write ? REQ_STORE : REQ_LOAD;

    // In IDLE the aligner judges the live request; afterwards it works from the latched copy.
    assign w_sel_addr = (r_state == IDLE) ? i_addr[1:0] : r_addr[1:0];
    assign w_sel_f3   = (r_state == IDLE) ? i_func3     : r_func3;

    assign w_invalid     = w_misaligned | f3_illegal(w_kind, i_func3);
    assign w_access      = (r_state == BUSY) && (r_cnt == '0);
    assign w_widx        = r_addr[AW+1:2];
    assign w_unused_addr = &{1'b0, i_addr[31:AW+2]};

    dmem_lane_align u_align (
        .i_addr_lo    (w_sel_addr),
        .i_func3      (w_sel_f3),
        .i_wdata      (r_wdata),
        .i_rword      (r_rword),
        .o_byte_en    (w_byte_en),
        .o_wword      (w_wword),
        .o_rdata      (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_invalid) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_fault <= 1'b0;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_fault <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are pure data: captured on acceptance, never reset.
    always_ff @(posedge i_clk) begin
        if ((r_state == IDLE) && w_req) begin
            r_kind  <= w_kind;
            r_func3 <= i_func3;
            r_addr  <= i_addr[AW+1:0];
            r_wdata <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_access) begin
            if (r_kind == REQ_STORE) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_byte_en[b]) begin
                        r_mem[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
                    end
                end
            end else begin
                r_rword <= r_mem[w_widx];
            end
        end
    end

    assign o_ready = r_ready;
    assign o_fault = r_fault;
    assign o_stall = w_req & ~r_ready;
    assign o_rdata = (r_ready && !r_fault && (r_kind == REQ_LOAD)) ? w_ld_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (0/1/3/7 wait states) sharing address/data lines,
// driven from a vector table through a scoreboard plus hand-written multi-cycle sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int ND = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        bit          ef;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          fault;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rd [ND];
    logic        mem_wr [ND];
    logic [31:0] rdata  [ND];
    logic        ready  [ND];
    logic        stall  [ND];
    logic        fault  [ND];

    vec_t vt[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
        dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_mem_read  (mem_rd[g]),
            .i_mem_write (mem_wr[g]),
            .i_func3     (func3),
            .i_addr      (addr),
            .i_wdata     (wdata),
            .o_rdata     (rdata[g]),
            .o_ready     (ready[g]),
            .o_stall     (stall[g]),
            .o_fault     (fault[g])
        );
    end

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input bit ef);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.er = er; v.ef = ef;
        vt.push_back(v);
    endtask

    // One request on instance d: drive at IDLE, wait for ready, compare, drop, let RESP retire.
    task automatic xact(input int d, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input bit ef, input string nm);
        exp_t e;
        exp_t act;
        int   n;
        bit   got;
        bit   stall_ok;
        @(negedge clk);
        func3 = f3; addr = a; wdata = wd; mem_rd[d] = rd; mem_wr[d] = wr;
        e.rdata = er; e.fault = ef; e.lat = ef ? 1 : ws_of(d) + 2;
        sb.push_back(e);
        #1;
        stall_ok = (stall[d] === 1'b1);
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[d] === 1'b1) got = 1;
            else if (stall[d] !== 1'b1) stall_ok = 0;
        end
        if (got && stall[d] !== 1'b0) stall_ok = 0;
        act.rdata = rdata[d]; act.fault = fault[d]; act.lat = n;
        mem_rd[d] = 1'b0; mem_wr[d] = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no ready after %0d cycles, want ready at cycle %0d", nm, n, e.lat);
        end else begin
            chk({nm, ".latency"}, 32'(act.lat), 32'(e.lat));
            chk({nm, ".rdata"}, act.rdata, e.rdata);
            chk({nm, ".fault"}, 32'(act.fault), 32'(e.fault));
            chk({nm, ".stall"}, 32'(stall_ok), 32'd1);
        end
        @(posedge clk);
    endtask

    initial begin
        int n;
        int cnt;
        int first;
        bit got;

        add(0, 1, F3_W,  32'h10,   32'hDEADBEEF, 32'h0,        0);
        add(1, 0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 0);
        add(0, 1, F3_B,  32'h11,   32'h00000080, 32'h0,        0);
        add(1, 0, F3_B,  32'h11,   32'h0,        32'hFFFFFF80, 0);
        add(1, 0, F3_BU, 32'h11,   32'h0,        32'h00000080, 0);
        add(1, 0, F3_W,  32'h10,   32'h0,        32'hDEAD80EF, 0);
        add(0, 1, F3_W,  32'h20,   32'h11112222, 32'h0,        0);
        add(0, 1, F3_H,  32'h22,   32'h00008001, 32'h0,        0);
        add(1, 0, F3_H,  32'h22,   32'h0,        32'hFFFF8001, 0);
        add(1, 0, F3_HU, 32'h22,   32'h0,        32'h00008001, 0);
        add(1, 0, F3_H,  32'h21,   32'h0,        32'h0,        1);
        add(1, 0, F3_W,  32'h20,   32'h0,        32'h80012222, 0);
        add(1, 0, F3_W,  32'h13,   32'h0,        32'h0,        1);
        add(1, 0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
        add(0, 1, F3_W,  32'h1002, 32'hCAFEBABE, 32'h0,        1);
        add(0, 1, F3_BU, 32'h10,   32'h000000AA, 32'h0,        1);
        add(1, 0, F3_W,  32'h10,   32'h0,        32'hDEAD80EF, 0);
        add(0, 1, F3_W,  32'h1000, 32'h12345678, 32'h0,        0);
        add(1, 0, F3_W,  32'h0,    32'h0,        32'h12345678, 0);
        add(0, 1, F3_B,  32'h13,   32'hFFFFFFA5, 32'h0,        0);
        add(1, 0, F3_W,  32'h10,   32'h0,        32'hA5AD80EF, 0);
        add(1, 0, F3_H,  32'h12,   32'h0,        32'hFFFFA5AD, 0);
        add(1, 0, F3_HU, 32'h10,   32'h0,        32'h000080EF, 0);
        add(1, 0, F3_B,  32'h10,   32'h0,        32'hFFFFFFEF, 0);
        add(0, 1, F3_H,  32'h10,   32'h12347FFF, 32'h0,        0);
        add(1, 0, F3_H,  32'h10,   32'h0,        32'h00007FFF, 0);
        add(1, 0, F3_B,  32'h12,   32'h0,        32'hFFFFFFAD, 0);
        add(1, 0, F3_BU, 32'h13,   32'h0,        32'h000000A5, 0);
        add(1, 0, 3'b110, 32'h10,  32'h0,        32'h0,        1);
        add(0, 1, F3_H,  32'h13,   32'h0000BEEF, 32'h0,        1);
        add(1, 1, F3_W,  32'h30,   32'h77665544, 32'h0,        0);
        add(1, 0, F3_W,  32'h30,   32'h0,        32'h77665544, 0);
        add(1, 1, F3_BU, 32'h30,   32'h0,        32'h0,        1);

        // Reset state, and stall following the request combinationally under reset.
        rst_n = 1'b0;
        func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        foreach (mem_rd[i]) begin
            mem_rd[i] = 1'b0;
            mem_wr[i] = 1'b0;
        end
        mem_rd[1] = 1'b1;
        #12;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset.ready%0d", d), 32'(ready[d]), 32'd0);
            chk($sformatf("reset.fault%0d", d), 32'(fault[d]), 32'd0);
            chk($sformatf("reset.rdata%0d", d), rdata[d], 32'h0);
        end
        chk("reset.stall_req", 32'(stall[1]), 32'd1);
        mem_rd[1] = 1'b0;
        #1;
        chk("reset.stall_idle", 32'(stall[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            xact(1, vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].wd, vt[i].er, vt[i].ef,
                 $sformatf("vec%0d", i));
        end

        // Request held continuously: one transaction per WAIT_STATES+3 cycles.
        @(negedge clk);
        func3 = F3_W; addr = 32'h10; mem_rd[1] = 1'b1;
        cnt = 0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (ready[1] === 1'b1) begin
                cnt++;
                if (first == 0) first = c;
                chk($sformatf("hold.rdata@%0d", c), rdata[1], 32'hA5AD7FFF);
            end
        end
        mem_rd[1] = 1'b0;
        chk("hold.count", 32'(cnt), 32'd3);
        chk("hold.first", 32'(first), 32'd3);
        @(posedge clk);

        // Latency sweep at the extremes of the wait-state range.
        xact(0, 0, 1, F3_W, 32'h40, 32'h55AA33CC, 32'h0,        0, "ws0.sw");
        xact(0, 1, 0, F3_W, 32'h40, 32'h0,        32'h55AA33CC, 0, "ws0.lw");
        xact(3, 0, 1, F3_W, 32'h40, 32'h0F0F0F0F, 32'h0,        0, "ws7.sw");
        xact(3, 1, 0, F3_W, 32'h40, 32'h0,        32'h0F0F0F0F, 0, "ws7.lw");
        xact(3, 1, 0, F3_W, 32'h41, 32'h0,        32'h0,        1, "ws7.fault");

        // Request withdrawn during BUSY still completes on the latched values.
        @(negedge clk);
        func3 = F3_W; addr = 32'h50; wdata = 32'hCAFEF00D; mem_wr[2] = 1'b1;
        @(posedge clk);
        #1;
        mem_wr[2] = 1'b0;
        func3 = 3'b111; addr = 32'h0; wdata = 32'h0;
        #1;
        chk("drop.stall", 32'(stall[2]), 32'd0);
        n = 1;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[2] === 1'b1) got = 1;
        end
        chk("drop.latency", 32'(n), 32'd5);
        @(posedge clk);
        xact(2, 1, 0, F3_W, 32'h50, 32'h0, 32'hCAFEF00D, 0, "drop.lw");

        // Reset mid-BUSY abandons the store.
        xact(2, 0, 1, F3_W, 32'h60, 32'h0BADF00D, 32'h0, 0, "rstb.sw_old");
        @(negedge clk);
        func3 = F3_W; addr = 32'h60; wdata = 32'h11223344; mem_wr[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstb.ready", 32'(ready[2]), 32'd0);
        chk("rstb.fault", 32'(fault[2]), 32'd0);
        chk("rstb.rdata", rdata[2], 32'h0);
        chk("rstb.stall", 32'(stall[2]), 32'd1);
        mem_wr[2] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        xact(2, 1, 0, F3_W, 32'h60, 32'h0, 32'h0BADF00D, 0, "rstb.lw");

        // Reset landing in the ready cycle clears the outputs at once.
        @(negedge clk);
        func3 = F3_W; addr = 32'h10; mem_rd[1] = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[1] === 1'b1) got = 1;
        end
        chk("rstr.ready_seen", 32'(got), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstr.ready", 32'(ready[1]), 32'd0);
        chk("rstr.rdata", rdata[1], 32'h0);
        mem_rd[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        xact(1, 1, 0, F3_W, 32'h10, 32'h0, 32'hA5AD7FFF, 0, "rstr.lw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: services the `mem_read` / `mem_write` requests raised by the control decoder for loads and stores. It owns a word-organised synchronous data RAM and performs byte/half/word accesses selected by `func3`, with sign or zero extension on loads. Completion is reported through a `ready` / `stall` handshake, so the core holds its PC while the configurable-latency access is in flight. Misaligned and illegal accesses are rejected with a fault pulse.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.
- `WAIT_STATES`, default 1: extra access cycles, legal range 0..7.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `mem_read`  in  1: load request.
- `mem_write`  in  1: store request.
- `func3`  in  3: access size and extension.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data; the lower bytes are used for SB and SH.
- `rdata`  out  32: extended load data; valid only while `ready`=1.
- `ready`  out  1: transaction complete, one-cycle pulse.
- `stall`  out  1: hold PC; combinational, `(mem_read|mem_write) & ~ready`.
- `fault`  out  1: misaligned or illegal access; pulses together with `ready`.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: access in progress.
  - RESP: one-cycle completion.
- IDLE behaviour:
  - When `mem_read|mem_write`=1, capture `addr`, `func3`, `wdata` and the request kind.
  - Write wins if both request inputs are high; `mem_read` is then ignored.
  - Valid request: load wait counter = `WAIT_STATES`, go to BUSY.
  - Invalid request: go straight to RESP with `fault`=1. No RAM access, `rdata`=0.
- Invalid request means any of:
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]` != 0.
  - Load with `func3` in {011, 110, 111}.
  - Store with `func3` > 010.
- BUSY behaviour:
  - Decrement the counter while it is nonzero.
  - At counter==0, perform the access and go to RESP.
  - Store: write only the byte lanes selected by the latched `addr[1:0]` and size.
  - Load: read the full word.
- RESP behaviour:
  - `ready`=1 for exactly one cycle.
  - `rdata` = selected byte/half/word, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - `rdata` = 0 for stores.
  - Next state is always IDLE. A request still present then is treated as a new transaction; the core advances PC in the `ready` cycle, so this is the next instruction's request.
- Word index = `addr[2 +: $clog2(DEPTH_WORDS)]`. Upper address bits are ignored, so out-of-range addresses wrap.
- The requester holds inputs stable until `ready`. If the request drops during BUSY, the transaction still completes on the latched values.
- RAM contents are not reset.

## Timing
- Reset values: state=IDLE, counter=0, `ready`=0, `fault`=0, `rdata`=0.
- `stall` follows the inputs combinationally, including during reset.
- Valid-access latency:
  - `ready` rises `WAIT_STATES`+2 cycles after the IDLE cycle in which the request is sampled.
  - With `WAIT_STATES`=0: request at cycle 0, access at cycle 1, `ready` at cycle 2.
- Store data is visible to a load issued in the cycle after the store's `ready`.
- Fault latency: `ready` and `fault` rise 1 cycle after sampling.
- Back-to-back transactions have one IDLE cycle between them, so throughput is one transaction per `WAIT_STATES`+3 cycles.
- Reset asserted mid-BUSY: return to IDLE immediately. Any pending store is abandoned, but a write already committed at counter==0 remains.
- `ready` and `fault` are registered outputs. `rdata` is driven from registered and latched state only.

## Structure
- Package `dmem_pkg` holds:
  - `func3` constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The state enum `dmem_state_t` {IDLE, BUSY, RESP}.
  - The request kind enum {REQ_LOAD, REQ_STORE}.
- Sub-module `dmem_lane_align` (combinational):
  - Inputs: `addr[1:0]`, `func3`, `wdata`, raw read word.
  - Outputs: 4-bit byte-enable, lane-shifted write word, extended load data, `misaligned` flag.
- The RAM is an inferred array inside `dmem_responder`, with a per-byte write enable.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 (`WAIT_STATES`=1):
  - `ready` 3 cycles after each request.
  - `rdata`=0xDEADBEEF.
  - `stall`=1 in every cycle before `ready`.
- After the SW above, SB 0x80 to 0x11, then:
  - LB 0x11 → 0xFFFFFF80.
  - LBU 0x11 → 0x00000080.
  - LW 0x10 → 0xDEAD80EF.
- SH 0x8001 to 0x22, then:
  - LH 0x22 → 0xFFFF8001.
  - LHU 0x22 → 0x00008001.
  - LH 0x21 → `fault`=1, `ready` after 1 cycle, `rdata`=0, RAM unchanged.
- LW 0x13 and load `func3`=011: each gives `fault`=1 with no RAM access. SW to 0x1002 with `DEPTH_WORDS`=1024 → `fault`=1.
- Address wrap with `DEPTH_WORDS`=1024: SW 0x12345678 to 0x1000 → LW 0x0000 returns 0x12345678.
- Reset and sweep:
  - Deassert `rst_n` during BUSY of an SW with `WAIT_STATES`=3: outputs return to 0 immediately, and a subsequent LW shows the old word unchanged.
  - Sweep `WAIT_STATES` over 0 and 7: latency is 2 and 9 cycles respectively.
